tmr_scrub_ctrl: RTL

TMR_SCRUB_CTRL -- requirements
Module: tmr_scrub_ctrl

---
 rtl/tmr_scrub_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/tmr_scrub_ctrl.sv
// -----------------------------------------------------------------------------
// tmr_scrub_ctrl
//
// Triple-modular-redundant register file with a periodic background scrubber.
// Three identical copies of a 2^ADDR_W x DATA_W register file are kept. Host
// reads return the bitwise 2-of-3 vote of the copies. A small FSM walks a
// scrub pointer over the file. After every SCRUB_PERIOD cycles of WAIT it
// compares the three copies at the pointer. On disagreement it rewrites all
// three copies with the voted word and reports the correction. Single-bit
// fault injection into any copy is provided for self-test.
//
// Ports
//   CP          clock, rising edge
//   CDN         synchronous active-low reset
//   wr_req      host write request; always accepted
//   wr_addr     host write address
//   wr_data     host write data
//   wr_ack      one-cycle acknowledge, registered copy of wr_req
//   rd_addr     host read address
//   rd_data     voted read data (combinational)
//   scrub_en    enables the periodic scrubber
//   clr_cnt     synchronous clear of seu_cnt
//   inj_en      fault-injection strobe
//   inj_copy    copy to corrupt (3 = no copy)
//   inj_addr    word to corrupt
//   inj_bit     bit to invert
//   seu_flag    one-cycle pulse per correction
//   seu_addr    address of the last correction
//   seu_cnt     saturating correction count
// -----------------------------------------------------------------------------
module tmr_scrub_ctrl #(
  parameter int                ADDR_W       = 3,
  parameter int                DATA_W       = 8,
  parameter int                SCRUB_PERIOD = 16,
  parameter logic [DATA_W-1:0] RESET_VAL    = '1,
  localparam int               BIT_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              CP,
  input  logic              CDN,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              scrub_en,
  input  logic              clr_cnt,
  input  logic              inj_en,
  input  logic [1:0]        inj_copy,
  input  logic [ADDR_W-1:0] inj_addr,
  input  logic [BIT_W-1:0]  inj_bit,
  output logic              seu_flag,
  output logic [ADDR_W-1:0] seu_addr,
  output logic [7:0]        seu_cnt
);

  localparam int                DEPTH      = 1 << ADDR_W;
  localparam logic [15:0]       TIMER_LAST = 16'(SCRUB_PERIOD - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [DATA_W-1:0] BIT_ONE    = DATA_W'(1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FIX   = 2'd2
  } state_t;

  // Bitwise 2-of-3 majority vote.
  function automatic logic [DATA_W-1:0] vote3(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [DATA_W-1:0] mem_r [3][DEPTH];

  state_t            state_r;
  logic [15:0]       timer_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [DATA_W-1:0] voted_r;

  logic [DATA_W-1:0] scrub_w0_s;
  logic [DATA_W-1:0] scrub_w1_s;
  logic [DATA_W-1:0] scrub_w2_s;
  logic [DATA_W-1:0] scrub_vote_s;
  logic              scrub_mismatch_s;
  logic              fix_write_s;
  logic              fix_done_s;
  logic              inj_hit_s;
  logic [DATA_W-1:0] inj_mask_s;

  assign rd_data = vote3(mem_r[0][rd_addr], mem_r[1][rd_addr], mem_r[2][rd_addr]);

  // Scrub-side decode: vote at the pointer, fix write / fix completion,
  // and whether an injection survives collisions with other writes.
  always_comb begin
    scrub_w0_s       = mem_r[0][ptr_r];
    scrub_w1_s       = mem_r[1][ptr_r];
    scrub_w2_s       = mem_r[2][ptr_r];
    scrub_vote_s     = vote3(scrub_w0_s, scrub_w1_s, scrub_w2_s);
    scrub_mismatch_s = (scrub_w0_s != scrub_w1_s) || (scrub_w1_s != scrub_w2_s);
    fix_write_s      = 1'b0;
    fix_done_s       = 1'b0;
    inj_hit_s        = 1'b0;
    inj_mask_s       = BIT_ONE << inj_bit;
    if (state_r == ST_FIX) begin
      // Host write owns the storage port; a host write to ptr itself
      // supersedes the fix, so the fix completes without writing.
      fix_write_s = ~wr_req;
      fix_done_s  = ~wr_req || (wr_addr == ptr_r);
    end else begin
      fix_write_s = 1'b0;
      fix_done_s  = 1'b0;
    end
    if (inj_en && (inj_copy != 2'd3)) begin
      // A full-word write landing on the same address replaces the word,
      // so the flipped bit would be lost anyway.
      inj_hit_s = !(wr_req && (wr_addr == inj_addr)) &&
                  !(fix_write_s && (ptr_r == inj_addr));
    end else begin
      inj_hit_s = 1'b0;
    end
  end

  // Triplicated storage: reset fill, host write, scrub fix and injection.
  always_ff @(posedge CP) begin
    if (!CDN) begin
      for (int c = 0; c < 3; c++) begin
        for (int a = 0; a < DEPTH; a++) begin
          mem_r[c][a] <= RESET_VAL;
        end
      end
    end else begin
      if (wr_req) begin
        for (int c = 0; c < 3; c++) begin
          mem_r[c][wr_addr] <= wr_data;
        end
      end else if (fix_write_s) begin
        for (int c = 0; c < 3; c++) begin
          mem_r[c][ptr_r] <= voted_r;
        end
      end else begin
        // storage holds
      end
      if (inj_hit_s) begin
        case (inj_copy)
          2'd0:    mem_r[0][inj_addr] <= mem_r[0][inj_addr] ^ inj_mask_s;
          2'd1:    mem_r[1][inj_addr] <= mem_r[1][inj_addr] ^ inj_mask_s;
          2'd2:    mem_r[2][inj_addr] <= mem_r[2][inj_addr] ^ inj_mask_s;
          default: ;
        endcase
      end else begin
        // no injection this cycle
      end
    end
  end

  // Scrub FSM plus the registered host/status outputs.
  always_ff @(posedge CP) begin
    if (!CDN) begin
      state_r  <= ST_WAIT;
      timer_r  <= 16'd0;
      ptr_r    <= '0;
      voted_r  <= '0;
      wr_ack   <= 1'b0;
      seu_flag <= 1'b0;
      seu_addr <= '0;
      seu_cnt  <= 8'd0;
    end else begin
      wr_ack   <= wr_req;
      seu_flag <= 1'b0;

      // Clear beats a coincident correction.
      if (clr_cnt) begin
        seu_cnt <= 8'd0;
      end else if (fix_done_s && (seu_cnt != 8'hFF)) begin
        seu_cnt <= seu_cnt + 8'd1;
      end else begin
        seu_cnt <= seu_cnt;
      end

      case (state_r)
        ST_WAIT: begin
          // Exit only while enabled, so dropping scrub_en parks the FSM here.
          if (!scrub_en) begin
            timer_r <= 16'd0;
          end else if (timer_r == TIMER_LAST) begin
            timer_r <= 16'd0;
            state_r <= ST_CHECK;
          end else begin
            timer_r <= timer_r + 16'd1;
          end
        end
        ST_CHECK: begin
          if (scrub_mismatch_s) begin
            voted_r <= scrub_vote_s;
            state_r <= ST_FIX;
          end else begin
            ptr_r   <= ptr_r + PTR_ONE;
            state_r <= ST_WAIT;
          end
        end
        ST_FIX: begin
          if (fix_done_s) begin
            seu_flag <= 1'b1;
            seu_addr <= ptr_r;
            ptr_r    <= ptr_r + PTR_ONE;
            state_r  <= ST_WAIT;
          end else begin
            state_r  <= ST_FIX;
          end
        end
        default: begin
          timer_r <= 16'd0;
          state_r <= ST_WAIT;
        end
      endcase
    end
  end

endmodule
